// File: rtl/pipe_adder.sv
// pipe_adder: elastic valid/ready pipelined ADD/SUB/ACC/CLR datapath.
// Arithmetic at input accept; STAGES register stages carry result/carry/ovf.
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   in_valid/in_ready operand beat handshake (op, src1, src2)
//   out_valid/out_ready result beat handshake (out, carry, ovf)
// Build option: define ADDER_SAT_EN to saturate ADD/SUB/ACC on signed
// overflow; undefined, results wrap modulo 2^WIDTH.
module pipe_adder #(
  parameter int WIDTH = 64,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             raw_v;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             acc_we;
  logic             take;

  // Operand steering: SUB is src1 + ~src2 + 1,
  // ACC adds src1 to the live accumulator.
  always_comb begin
    opa    = src1;
    opb    = src2;
    cin    = 1'b0;
    acc_we = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        opb = src2;
      end
      (op == OP_SUB): begin
        opb = ~src2;
        cin = 1'b1;
      end
      (op == OP_ACC): begin
        opa    = acc;
        opb    = src1;
        acc_we = 1'b1;
      end
      (op == OP_CLR): begin
        acc_we = 1'b1;
      end
    endcase
  end

  assign sum = {1'b0, opa} + {1'b0, opb}
             + {{WIDTH{1'b0}}, cin};

  // Same-sign operands producing a different-sign
  // result is a two's complement overflow.
  assign raw_v = (opa[WIDTH-1] == opb[WIDTH-1])
              && (sum[WIDTH-1] != opa[WIDTH-1]);

  always_comb begin
    res   = sum[WIDTH-1:0];
    res_c = sum[WIDTH];
    res_v = raw_v;
`ifdef ADDER_SAT_EN
    // On overflow both operands share a sign;
    // that sign picks the clamp direction.
    if (raw_v) begin
      if (opa[WIDTH-1])
        res = {1'b1, {(WIDTH-1){1'b0}}};
      else
        res = {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    if (op == OP_CLR) begin
      res   = RESET_VAL;
      res_c = 1'b0;
      res_v = 1'b0;
    end
  end

  // Pipeline stage registers.
  logic [STAGES-1:0] v;
  logic [STAGES:0]   rdy;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] c;
  logic [STAGES-1:0] o;

  // A stage is ready when empty or when the
  // stage behind it drains this cycle.
  always_comb begin
    logic r;
    r = out_ready;
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r = !v[i] || r;
      rdy[i] = r;
    end
  end

  assign take = in_valid && rdy[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= RESET_VAL;
      v   <= '0;
      c   <= '0;
      o   <= '0;
      for (int i = 0; i < STAGES; i++)
        d[i] <= RESET_VAL;
    end else begin
      // Accumulator commits at accept, so a
      // following ACC sees it with no bubble.
      if (take && acc_we)
        acc <= res;
      if (rdy[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          d[0] <= res;
          c[0] <= res_c;
          o[0] <= res_v;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
            c[i] <= c[i-1];
            o[i] <= o[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES-1];
  assign out       = d[STAGES-1];
  assign carry     = c[STAGES-1];
  assign ovf       = o[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed + random bench for pipe_adder with a
// queue-based reference model evaluated at input accept.
module tb_pipe_adder;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry;
  logic         ovf;

  always #5 clk = ~clk;

  pipe_adder #(
    .WIDTH(W),
    .STAGES(2),
    .RESET_VAL('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .src1(src1),
    .src2(src2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .carry(carry),
    .ovf(ovf)
  );

  typedef struct packed {
    logic [W-1:0] val;
    logic         c;
    logic         v;
  } res_t;

  res_t         exp_q[$];
  logic [W-1:0] got[$];
  int           got_cyc[$];
  logic [W-1:0] acc_m;
  int           n_pass;
  int           n_total;
  int           cyc;
  bit           took;
  bit           popped;
  bit           stalled;
  logic [W-1:0] held;
  res_t         last;

  task automatic chk(string tag,
                     logic [W-1:0] obs,
                     logic [W-1:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, expv);
  endtask

  // Reference: exact signed/unsigned math in wider
  // integers, then reduced to WIDTH bits.
  function automatic res_t model(logic [1:0] o,
                                 logic [W-1:0] a,
                                 logic [W-1:0] b);
    logic signed [W+1:0] sa, sb, sacc, s;
    logic [W:0] u;
    res_t r;
    sa   = $signed({{2{a[W-1]}}, a});
    sb   = $signed({{2{b[W-1]}}, b});
    sacc = $signed({{2{acc_m[W-1]}}, acc_m});
    r = '0;
    s = '0;
    case (o)
      2'd0: begin
        s = sa + sb;
        u = {1'b0, a} + {1'b0, b};
        r.c = u[W];
      end
      2'd1: begin
        s = sa - sb;
        r.c = (a >= b);
      end
      2'd2: begin
        s = sacc + sa;
        u = {1'b0, acc_m} + {1'b0, a};
        r.c = u[W];
      end
      default: begin
        acc_m = '0;
        return '0;
      end
    endcase
    // Overflow: true result does not fit W signed bits.
    r.v = (s[W+1:W-1] != {3{s[W+1]}});
    r.val = s[W-1:0];
`ifdef ADDER_SAT_EN
    if (r.v)
      r.val = s[W+1] ? {1'b1, {(W-1){1'b0}}}
                     : {1'b0, {(W-1){1'b1}}};
`endif
    if (o == 2'd2)
      acc_m = r.val;
    return r;
  endfunction

  task automatic tick();
    res_t e;
    @(negedge clk);
    cyc++;
    took   = in_valid && in_ready;
    popped = out_valid && out_ready;
    if (stalled)
      chk("stall_hold", out, held);
    stalled = out_valid && !out_ready;
    held    = out;
    if (popped) begin
      chk("beat_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out", out, e.val);
        chk("carry", W'(carry), W'(e.c));
        chk("ovf", W'(ovf), W'(e.v));
      end
      last = {out, carry, ovf};
      got.push_back(out);
      got_cyc.push_back(cyc);
    end
    if (took)
      exp_q.push_back(model(op, src1, src2));
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [1:0] o,
                      logic [W-1:0] a,
                      logic [W-1:0] b);
    int n;
    in_valid = 1'b1;
    op = o;
    src1 = a;
    src2 = b;
    n = 0;
    do begin
      tick();
      n++;
    end while (!took && n < 50);
    chk("accept_bound", W'(took), W'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain(output int lat);
    lat = 0;
    while (exp_q.size() != 0 && lat < 50) begin
      tick();
      lat++;
    end
    chk("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      4: return W'($urandom_range(0, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int k;
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    stalled = 0;
    acc_m = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    op = 2'd0;
    src1 = '0;
    src2 = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out", out, '0);
    chk("rst_carry", W'(carry), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    rst = 1'b0;
    chk("rel_in_ready", W'(in_ready), W'(1));

    // ADD all-ones + 1, with latency.
    send(2'd0, '1, W'(1));
    drain(lat);
    chk("add_lat", W'(lat), W'(2));
    chk("add_out", last.val, '0);
    chk("add_carry", W'(last.c), W'(1));
    chk("add_ovf", W'(last.v), W'(0));

    // SUB 5 - 7.
    send(2'd1, W'(5), W'(7));
    drain(lat);
    chk("sub_out", last.val, {{(W-1){1'b1}}, 1'b0});
    chk("sub_carry", W'(last.c), W'(0));
    chk("sub_ovf", W'(last.v), W'(0));

    // CLR, ACC 3, 4, 5 back-to-back.
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 4);
      op = (i == 0) ? 2'd3 : 2'd2;
      src1 = W'(i + 2);
      src2 = '1;
      tick();
    end
    in_valid = 1'b0;
    chk("acc_count", W'(got.size()), W'(4));
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("acc_val", got[i], W'(i * (i + 5) / 2));
      chk("acc_cycle", W'(got_cyc[i] - got_cyc[0]), W'(i));
    end

    // Output stall: 6 cycles, ADD i+i.
    got.delete();
    out_ready = 1'b0;
    k = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (k <= 5);
      op = 2'd0;
      src1 = W'(k);
      src2 = W'(k);
      tick();
      if (took) k++;
    end
    chk("stall_accepts", W'(k - 1), W'(2));
    chk("stall_in_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    while (k <= 5) begin
      send(2'd0, W'(k), W'(k));
      k++;
    end
    drain(lat);
    chk("stall_count", W'(got.size()), W'(5));
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("stall_val", got[i], W'(2 * (i + 1)));

    // Signed overflow.
    send(2'd0, {1'b0, {(W-1){1'b1}}}, W'(1));
    drain(lat);
    chk("ovf_flag", W'(last.v), W'(1));
`ifdef ADDER_SAT_EN
    chk("ovf_out", last.val, {1'b0, {(W-1){1'b1}}});
`else
    chk("ovf_out", last.val, {1'b1, {(W-1){1'b0}}});
`endif

    // Reset with two beats in flight.
    send(2'd2, W'(9), '0);
    drain(lat);
    in_valid = 1'b1;
    op = 2'd0;
    src1 = W'(11);
    src2 = W'(22);
    tick();
    src1 = W'(33);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_out", out, '0);
    exp_q.delete();
    acc_m = '0;
    stalled = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rel_ready", W'(in_ready), W'(1));
    repeat (3) tick();
    send(2'd2, W'(1), '0);
    drain(lat);
    chk("acc_after_rst", last.val, W'(1));

    // Randomized traffic.
    in_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = 2'($urandom_range(0, 3));
        src1 = pick();
        src2 = pick();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
